// File: rtl/branch_ctrl_if.sv
// Handshake and result bundle between decode/execute, the branch controller and fetch.
// The master side offers ops and acknowledges redirects; the slave side is the controller.
interface branch_ctrl_if;
    logic        br_valid;
    logic        br_ready;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1_d;
    logic [31:0] rs2_d;
    logic [2:0]  funct3;
    logic        is_jal;
    logic        is_jalr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ack;
    logic        flush;
    logic [31:0] link_data;
    logic        taken;
    logic        exc_valid;
    logic [1:0]  exc_cause;
    logic        done;

    modport master (
        output br_valid, pc, imm, rs1_d, rs2_d, funct3, is_jal, is_jalr, redirect_ack,
        input  br_ready, redirect_valid, redirect_pc, flush, link_data, taken,
               exc_valid, exc_cause, done
    );

    modport slave (
        input  br_valid, pc, imm, rs1_d, rs2_d, funct3, is_jal, is_jalr, redirect_ack,
        output br_ready, redirect_valid, redirect_pc, flush, link_data, taken,
               exc_valid, exc_cause, done
    );
endinterface

// File: rtl/branch_ctrl.sv
// Resolves one RV32I control-transfer op at a time: evaluates the condition and target,
// drives the fetch redirect handshake and the flush window, then pulses done.
module branch_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input logic         clk,
    input logic         rst,
    branch_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        EVAL,
        REDIRECT,
        FLUSH,
        DONE
    } state_t;

    state_t      state, state_nxt;

    logic [31:0] pc_q, imm_q, rs1_q, rs2_q;
    logic [2:0]  f3_q;
    logic        jal_q, jalr_q;

    logic [31:0] target_q, link_q;
    logic        taken_q;
    logic [1:0]  exc_q;
    logic [3:0]  cnt_q;

    logic        is_branch, cond, illegal, taken_c, misalign;
    logic [31:0] target_c;
    logic [1:0]  exc_c;

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        is_branch = !(jal_q || jalr_q);
        cond      = 1'b0;
        illegal   = 1'b0;
        case (f3_q)
            3'b000:  cond = (rs1_q == rs2_q);
            3'b001:  cond = (rs1_q != rs2_q);
            3'b100:  cond = ($signed(rs1_q) <  $signed(rs2_q));
            3'b101:  cond = ($signed(rs1_q) >= $signed(rs2_q));
            3'b110:  cond = (rs1_q <  rs2_q);
            3'b111:  cond = (rs1_q >= rs2_q);
            default: illegal = is_branch;
        endcase
        // JALR wins when both jump flags are set.
        target_c = jalr_q ? ((rs1_q + imm_q) & ~32'h1) : (pc_q + imm_q);
        taken_c  = !is_branch || cond;
        misalign = taken_c && target_c[1];
        exc_c    = illegal ? 2'b10 : (misalign ? 2'b01 : 2'b00);
    end

    always_comb begin
        state_nxt          = state;
        bus.br_ready       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.flush          = 1'b0;
        bus.done           = 1'b0;
        bus.exc_valid      = 1'b0;
        case (state)
            IDLE: begin
                bus.br_ready = 1'b1;
                if (bus.br_valid) state_nxt = EVAL;
            end
            EVAL: begin
                state_nxt = (taken_c && exc_c == 2'b00) ? REDIRECT : DONE;
            end
            REDIRECT: begin
                bus.redirect_valid = 1'b1;
                bus.flush          = 1'b1;
                if (bus.redirect_ack) state_nxt = FLUSH;
            end
            FLUSH: begin
                bus.flush = 1'b1;
                if (cnt_q == 4'd1) state_nxt = DONE;
            end
            DONE: begin
                bus.done      = 1'b1;
                bus.exc_valid = (exc_q != 2'b00);
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.redirect_pc = target_q;
    assign bus.link_data   = link_q;
    assign bus.taken       = taken_q;
    assign bus.exc_cause   = exc_q;

    // NOTE: state and data registers use non-blocking assignments so all of them update
    // from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            pc_q     <= '0;
            imm_q    <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            f3_q     <= '0;
            jal_q    <= 1'b0;
            jalr_q   <= 1'b0;
            target_q <= '0;
            link_q   <= '0;
            taken_q  <= 1'b0;
            exc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && bus.br_valid) begin
                pc_q   <= bus.pc;
                imm_q  <= bus.imm;
                rs1_q  <= bus.rs1_d;
                rs2_q  <= bus.rs2_d;
                f3_q   <= bus.funct3;
                jal_q  <= bus.is_jal;
                jalr_q <= bus.is_jalr;
            end
            if (state == EVAL) begin
                target_q <= target_c;
                link_q   <= pc_q + 32'd4;
                taken_q  <= taken_c;
                exc_q    <= exc_c;
            end
            if (state == REDIRECT && bus.redirect_ack) begin
                cnt_q <= 4'(FLUSH_CYCLES);
            end else if (state == FLUSH) begin
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end

endmodule
